// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 select decoder.
// Grants are registered, bounded to MAX_HOLD cycles and separated by a 1-cycle RELEASE gap.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic [7:0] grant_onehot,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [2:0]          idx_q, idx_d;
  logic                en_q, en_d;
  logic [7:0]          onehot_q, onehot_d;
  logic                busy_q, busy_d;

  logic                arb_go;
  logic                grant_end;
  logic [3:0]          pick;
  logic                win_found;
  logic [2:0]          win_idx;

  // Search ptr, ptr+1, ... with natural 3-bit wrap; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] c;
    logic       found;
    logic [2:0] w;
    found = 1'b0;
    w     = p;
    for (int k = 0; k < 8; k++) begin
      c = p + 3'(k);
      if (!found && r[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    return {found, w};
  endfunction

  assign pick      = rr_pick(req, ptr_q);
  assign win_found = pick[3];
  assign win_idx   = pick[2:0];
  assign arb_go    = enable && win_found;
  assign grant_end = !enable || !req[idx_q] || (hold_q == HOLD_W'(MAX_HOLD - 1));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd0;
      hold_q   <= '0;
      idx_q    <= 3'd0;
      en_q     <= 1'b0;
      onehot_q <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; IDLE and RELEASE arbitrate identically.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RELEASE: state_d = arb_go ? GRANT : IDLE;
      GRANT:         state_d = grant_end ? RELEASE : GRANT;
      default:       state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    en_d     = 1'b0;
    onehot_d = 8'h00;
    case (state_q)
      IDLE, RELEASE: begin
        if (arb_go) begin
          idx_d    = win_idx;
          en_d     = 1'b1;
          onehot_d = 8'b1 << win_idx;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          ptr_d = idx_q + 3'd1;
        end else begin
          hold_d   = hold_q + 1'b1;
          en_d     = 1'b1;
          onehot_d = onehot_q;
        end
      end
      default: begin
        en_d = 1'b0;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  assign grant_idx    = idx_q;
  assign grant_en     = en_q;
  assign grant_onehot = onehot_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios then random traffic, every cycle
// compared against a grant-ownership model of the arbitration rules.
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic [7:0] grant_onehot;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference state: who owns the grant (-1 = nobody), how long, and where search starts.
  int owner    = -1;
  int last_idx = 0;
  int held     = 0;
  int ptr      = 0;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .grant_idx    (grant_idx),
    .grant_en     (grant_en),
    .grant_onehot (grant_onehot),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    last_idx = 0;
    held     = 0;
    ptr      = 0;
  endtask

  task automatic model_update(input logic e, input logic [7:0] r);
    int i;
    if (owner >= 0) begin
      if (!e || !r[owner] || held == MAX_HOLD - 1) begin
        ptr   = (owner + 1) % 8;
        owner = -1;
      end else begin
        held++;
      end
    end else if (e && r != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        i = (ptr + k) % 8;
        if (r[i]) begin
          owner    = i;
          last_idx = i;
          held     = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"},     32'(grant_en),     32'(owner >= 0));
    chk({tag, ".idx"},    32'(grant_idx),    32'(last_idx));
    chk({tag, ".onehot"}, 32'(grant_onehot), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk({tag, ".busy"},   32'(busy),         32'(owner >= 0));
  endtask

  // Called at a negedge: apply inputs, advance one clock, check at the next negedge.
  task automatic step(input string tag, input logic e, input logic [7:0] r);
    enable = e;
    req    = r;
    model_update(e, r);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".en"},     32'(grant_en),     32'd0);
    chk({tag, ".idx"},    32'(grant_idx),    32'd0);
    chk({tag, ".onehot"}, 32'(grant_onehot), 32'd0);
    chk({tag, ".busy"},   32'(busy),         32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   hold_left;
    logic e_r;
    logic [7:0] r_r;

    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Sole requester 5 held: 4-cycle grants separated by 1-cycle gaps.
    for (int c = 0; c < 12; c++) step("sole5", 1'b1, 8'h20);
    step("sole5_drop", 1'b1, 8'h00);
    step("idle", 1'b1, 8'h00);

    // Reset in the middle of a grant, then the search restarts at 0.
    step("pre_rst", 1'b1, 8'h10);
    step("pre_rst", 1'b1, 8'h10);
    async_reset_check("rst_mid");
    check_all("after_rst");
    step("ptr0", 1'b1, 8'h18);
    chk("ptr0_winner", 32'(grant_idx), 32'd3);

    // All requesting: rotate 0..7 and back to 0.
    async_reset_check("rst2");
    for (int c = 0; c < 42; c++) step("all", 1'b1, 8'hFF);
    step("all_off", 1'b1, 8'h00);

    // Requester 3 holds for 2 grant cycles only.
    step("r3", 1'b1, 8'h08);
    step("r3", 1'b1, 8'h08);
    step("r3_drop", 1'b1, 8'h00);
    step("r3_gap", 1'b1, 8'h00);

    // Pointer wrap 7 -> 0: finish a grant on 6, then 7 and 0 contend.
    step("g6", 1'b1, 8'h40);
    step("g6_drop", 1'b1, 8'h00);
    for (int c = 0; c < 12; c++) step("wrap", 1'b1, 8'h81);
    step("wrap_off", 1'b1, 8'h00);

    // Enable dropped mid-grant, held low with requests pending, then resumes.
    step("en", 1'b1, 8'h06);
    step("en", 1'b1, 8'h06);
    for (int c = 0; c < 4; c++) step("en_off", 1'b0, 8'h06);
    for (int c = 0; c < 6; c++) step("en_on", 1'b1, 8'h06);
    step("en_idle", 1'b1, 8'h00);

    // Random traffic with requests held for random spans.
    hold_left = 0;
    e_r = 1'b1;
    r_r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if (hold_left == 0) begin
        hold_left = $urandom_range(1, 8);
        e_r = ($urandom_range(0, 7) != 0);
        r_r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      end
      hold_left--;
      if (c == 300) async_reset_check("rst_rand");
      step("rand", e_r, r_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
